block_transfer_sequencer: RTL and testbench

Multi-cycle load/store-multiple sequencer that drives the register file's write port and one read port on behalf of ARM LDM/STM instructions. It walks a 16-bit register list in ascending order and moves one register per memory beat between memory and the register file. It also generates the word addresses and the optional base-register writeback. It sits between the decode/control stage and the register file / data memory, and holds the pipeline via `busy` while active.

---
 rtl/block_transfer_sequencer_if.sv | 42 ++++
 rtl/block_transfer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/block_transfer_sequencer_if.sv
// Command, register-file and data-memory signals of the LDM/STM sequencer.
// The sequencer side uses the master modport; the core/regfile/memory side uses slave.
interface block_transfer_sequencer_if;
  logic        start;
  logic        isLoad;
  logic        upward;
  logic        preIndex;
  logic        writeBack;
  logic [15:0] regList;
  logic [3:0]  baseReg;
  logic [31:0] baseValue;

  logic [3:0]  readReg;
  logic [31:0] readData;
  logic [3:0]  writeDestination;
  logic        writeEnable;
  logic [31:0] writeData;

  logic [31:0] memAddr;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memReady;

  logic        busy;
  logic        done;

  modport master (
    input  start, isLoad, upward, preIndex, writeBack, regList, baseReg, baseValue,
    input  readData, memReadData, memReady,
    output readReg, writeDestination, writeEnable, writeData,
    output memAddr, memRead, memWrite, memWriteData, busy, done
  );

  modport slave (
    output start, isLoad, upward, preIndex, writeBack, regList, baseReg, baseValue,
    output readData, memReadData, memReady,
    input  readReg, writeDestination, writeEnable, writeData,
    input  memAddr, memRead, memWrite, memWriteData, busy, done
  );
endinterface

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first, one register per memory beat,
// then optionally writes the updated base register back.
module block_transfer_sequencer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input logic                         clk,
  input logic                         reset,
  block_transfer_sequencer_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StWb, StDone} state_e;

  localparam logic [31:0] Step = 32'(WORD_BYTES);

  state_e      stateQ;
  logic [15:0] maskQ;
  logic [31:0] addrQ;
  logic [31:0] finalBaseQ;
  logic        wbQ;
  logic        loadQ;
  logic [3:0]  baseRegQ;
  logic        busyQ;
  logic        doneQ;

  function automatic logic [4:0] popCount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  logic [4:0]  cnt;
  logic [31:0] span;
  logic [31:0] startAddr;
  logic [31:0] finalBase;
  logic        needWb;

  // Every addressing mode walks upward from the lowest address of the block.
  always_comb begin
    cnt       = popCount(bus.regList);
    span      = 32'(cnt) * Step;
    startAddr = bus.baseValue;
    case ({bus.upward, bus.preIndex})
      2'b10:   startAddr = bus.baseValue;
      2'b11:   startAddr = bus.baseValue + Step;
      2'b00:   startAddr = bus.baseValue - span + Step;
      default: startAddr = bus.baseValue - span;
    endcase
    finalBase = bus.upward ? (bus.baseValue + span) : (bus.baseValue - span);
    // A loaded base register takes priority over the writeback value.
    needWb    = bus.writeBack && !(bus.isLoad && bus.regList[bus.baseReg]);
  end

  logic [3:0] curReg;
  logic       lastBeat;

  always_comb begin
    curReg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (maskQ[i]) curReg = 4'(i);
    end
    lastBeat = (maskQ & (maskQ - 16'd1)) == 16'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ     <= StIdle;
      maskQ      <= '0;
      addrQ      <= '0;
      finalBaseQ <= '0;
      wbQ        <= 1'b0;
      loadQ      <= 1'b0;
      baseRegQ   <= '0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (bus.start) begin
            loadQ      <= bus.isLoad;
            baseRegQ   <= bus.baseReg;
            maskQ      <= bus.regList;
            addrQ      <= startAddr;
            finalBaseQ <= finalBase;
            wbQ        <= needWb;
            busyQ      <= 1'b1;
            if (cnt == 5'd0) begin
              stateQ <= StDone;
              doneQ  <= 1'b1;
            end else begin
              stateQ <= StXfer;
            end
          end
        end
        StXfer: begin
          if (bus.memReady) begin
            maskQ <= maskQ & ~(16'd1 << curReg);
            addrQ <= addrQ + Step;
            if (lastBeat) begin
              if (wbQ) begin
                stateQ <= StWb;
              end else begin
                stateQ <= StDone;
                doneQ  <= 1'b1;
              end
            end
          end
        end
        StWb: begin
          stateQ <= StDone;
          doneQ  <= 1'b1;
        end
        StDone: begin
          stateQ <= StIdle;
          busyQ  <= 1'b0;
          doneQ  <= 1'b0;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.readReg          = '0;
    bus.writeDestination = '0;
    bus.writeEnable      = 1'b0;
    bus.writeData        = '0;
    bus.memAddr          = '0;
    bus.memRead          = 1'b0;
    bus.memWrite         = 1'b0;
    bus.memWriteData     = '0;
    case (stateQ)
      StXfer: begin
        bus.memAddr = addrQ;
        if (loadQ) begin
          bus.memRead = 1'b1;
          if (bus.memReady) begin
            bus.writeEnable      = 1'b1;
            bus.writeDestination = curReg;
            bus.writeData        = bus.memReadData;
          end
        end else begin
          bus.readReg      = curReg;
          bus.memWrite     = 1'b1;
          bus.memWriteData = bus.readData;
        end
      end
      StWb: begin
        bus.writeEnable      = 1'b1;
        bus.writeDestination = baseRegQ;
        bus.writeData        = finalBaseQ;
      end
      default: ;
    endcase
  end

  assign bus.busy = busyQ;
  assign bus.done = doneQ;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Self-checking bench for block_transfer_sequencer: directed test-plan cases plus randomized
// transfers checked cycle by cycle against a list/arithmetic reference model.
module tb_block_transfer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_transfer_sequencer_if bus();

  block_transfer_sequencer #(.WORD_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] regSeed;
  logic [31:0] memSeed;

  // Register file and memory stand-ins with data derived from the address.
  assign bus.readData    = regSeed ^ {8{bus.readReg}};
  assign bus.memReadData = bus.memAddr ^ memSeed;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string ctx);
    check({ctx, " memRead"}, 32'(bus.memRead), 32'd0);
    check({ctx, " memWrite"}, 32'(bus.memWrite), 32'd0);
    check({ctx, " writeEnable"}, 32'(bus.writeEnable), 32'd0);
    check({ctx, " memAddr"}, bus.memAddr, 32'd0);
    check({ctx, " done"}, 32'(bus.done), 32'd0);
    check({ctx, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic runOp(input bit load, input bit up, input bit pre, input bit wb,
                       input logic [15:0] list, input logic [3:0] bReg, input logic [31:0] base,
                       input int stallMax, input int stallBeat, input int stallLen,
                       input bit poke);
    logic [3:0]  regsQ[$];
    logic [31:0] span, lowAddr, finalBase, addr;
    bit          needWb;
    int          n, stalls;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        regsQ.push_back(4'(i));
        n++;
      end
    end
    span = 32'(n) * 32'd4;
    if (up) lowAddr = pre ? base + 32'd4 : base;
    else    lowAddr = pre ? base - span : base - span + 32'd4;
    finalBase = up ? base + span : base - span;
    needWb    = (n != 0) && wb && !(load && list[bReg]);
    regSeed   = $urandom;
    memSeed   = $urandom;

    @(negedge clk);
    bus.isLoad    = load;
    bus.upward    = up;
    bus.preIndex  = pre;
    bus.writeBack = wb;
    bus.regList   = list;
    bus.baseReg   = bReg;
    bus.baseValue = base;
    bus.memReady  = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    for (int k = 0; k < n; k++) begin
      stalls = (k == stallBeat) ? stallLen : int'($urandom_range(stallMax, 0));
      addr   = lowAddr + 32'(k) * 32'd4;
      for (int s = 0; s <= stalls; s++) begin
        bus.memReady = (s == stalls);
        if (poke && k == 0 && s == 0) begin
          bus.start   = 1'b1;
          bus.regList = ~list;
        end
        #1;
        check("xfer memAddr", bus.memAddr, addr);
        check("xfer memRead", 32'(bus.memRead), 32'(load));
        check("xfer memWrite", 32'(bus.memWrite), 32'(!load));
        check("xfer busy", 32'(bus.busy), 32'd1);
        check("xfer done", 32'(bus.done), 32'd0);
        if (load) begin
          check("load writeEnable", 32'(bus.writeEnable), 32'(bus.memReady));
          if (bus.memReady) begin
            check("load writeDestination", 32'(bus.writeDestination), 32'(regsQ[k]));
            check("load writeData", bus.writeData, addr ^ memSeed);
          end
        end else begin
          check("store writeEnable", 32'(bus.writeEnable), 32'd0);
          check("store readReg", 32'(bus.readReg), 32'(regsQ[k]));
          check("store memWriteData", bus.memWriteData, regSeed ^ {8{regsQ[k]}});
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.regList = list;
      end
    end

    if (needWb) begin
      bus.memReady = 1'($urandom);
      #1;
      check("wb writeEnable", 32'(bus.writeEnable), 32'd1);
      check("wb writeDestination", 32'(bus.writeDestination), 32'(bReg));
      check("wb writeData", bus.writeData, finalBase);
      check("wb strobes", 32'({bus.memRead, bus.memWrite}), 32'd0);
      check("wb done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end

    bus.memReady = 1'($urandom);
    #1;
    check("done pulse", 32'(bus.done), 32'd1);
    check("done busy", 32'(bus.busy), 32'd1);
    check("done writeEnable", 32'(bus.writeEnable), 32'd0);
    check("done strobes", 32'({bus.memRead, bus.memWrite}), 32'd0);
    @(negedge clk);
    #1;
    checkQuiet("after done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    regSeed       = 32'h0;
    memSeed       = 32'h0;
    bus.start     = 1'b0;
    bus.isLoad    = 1'b0;
    bus.upward    = 1'b0;
    bus.preIndex  = 1'b0;
    bus.writeBack = 1'b0;
    bus.regList   = '0;
    bus.baseReg   = '0;
    bus.baseValue = '0;
    bus.memReady  = 1'b0;
    reset         = 1'b1;
    #1;
    checkQuiet("reset");
    check("reset readReg", 32'(bus.readReg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // STM IA, writeback, r0..r3 from 0x1000, base r13.
    runOp(1'b0, 1'b1, 1'b0, 1'b1, 16'h000F, 4'd13, 32'h0000_1000, 0, -1, 0, 1'b0);
    // LDM DB, writeback, r4 and r15.
    runOp(1'b1, 1'b0, 1'b1, 1'b1, 16'h8010, 4'd0, 32'h0000_2000, 0, -1, 0, 1'b0);
    // STM IA with a three-cycle stall on the second beat.
    runOp(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 4'd5, 32'h0000_0400, 0, 1, 3, 1'b0);
    // LDM IA with base r2 in the list: no writeback cycle.
    runOp(1'b1, 1'b1, 1'b0, 1'b1, 16'h0006, 4'd2, 32'h0000_0500, 0, -1, 0, 1'b0);
    // Address wrap-around.
    runOp(1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 4'd8, 32'hFFFF_FFF8, 0, -1, 0, 1'b0);
    // Empty list.
    runOp(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd3, 32'h0000_0600, 0, -1, 0, 1'b0);
    // start pulsed during XFER must be ignored.
    runOp(1'b0, 1'b1, 1'b1, 1'b0, 16'h0A0A, 4'd1, 32'h0000_0700, 0, -1, 0, 1'b1);

    // Reset in the second XFER cycle of an STM.
    @(negedge clk);
    bus.isLoad    = 1'b0;
    bus.upward    = 1'b1;
    bus.preIndex  = 1'b0;
    bus.writeBack = 1'b1;
    bus.regList   = 16'h00F0;
    bus.baseReg   = 4'd9;
    bus.baseValue = 32'h0000_3000;
    bus.memReady  = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("pre-reset memAddr", bus.memAddr, 32'h0000_3000);
    @(negedge clk);
    #1;
    check("pre-reset memAddr 2", bus.memAddr, 32'h0000_3004);
    reset = 1'b1;
    #1;
    checkQuiet("mid reset");
    check("mid reset readReg", 32'(bus.readReg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkQuiet("post reset");
      @(negedge clk);
    end
    runOp(1'b1, 1'b0, 1'b0, 1'b1, 16'h0111, 4'd7, 32'h0000_8000, 1, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] list;
      list = ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom);
      runOp(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), list, 4'($urandom),
            $urandom, 2, -1, 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
